// File: rtl/assoc_cache_if.sv
// assoc_cache_if: processor-side and memory-side signals of assoc_cache.
//   CPU side    : cpuReq, cpuWe, cacheReadAddress, cpuWriteData -> cache; out, cpuAck, Hit, Miss <- cache
//   Memory side : memRead, memAddress, memWriteCacheOutput, memWriteAddress, memWriteData <- cache;
//                 dataIn, memReady -> cache
// Modports: slave = the cache, master = the processor/memory environment.
interface assoc_cache_if #(
  parameter int unsigned ADDR_W      = 15,
  parameter int unsigned BLOCK_WORDS = 4
);
  logic                      cpuReq;
  logic                      cpuWe;
  logic [ADDR_W-1:0]         cacheReadAddress;
  logic [31:0]               cpuWriteData;
  logic [31:0]               out;
  logic                      cpuAck;
  logic                      Hit;
  logic                      Miss;
  logic                      memRead;
  logic [ADDR_W-1:0]         memAddress;
  logic                      memWriteCacheOutput;
  logic [ADDR_W-1:0]         memWriteAddress;
  logic [31:0]               memWriteData;
  logic [32*BLOCK_WORDS-1:0] dataIn;
  logic                      memReady;

  modport slave (
    input  cpuReq, cpuWe, cacheReadAddress, cpuWriteData, dataIn, memReady,
    output out, cpuAck, Hit, Miss, memRead, memAddress, memWriteCacheOutput,
           memWriteAddress, memWriteData
  );

  modport master (
    output cpuReq, cpuWe, cacheReadAddress, cpuWriteData, dataIn, memReady,
    input  out, cpuAck, Hit, Miss, memRead, memAddress, memWriteCacheOutput,
           memWriteAddress, memWriteData
  );
endinterface

// File: rtl/assoc_cache.sv
// assoc_cache: N-way set-associative, write-through, no-write-allocate cache.
// Ports:
//   clock, rst : clock and synchronous active-high reset
//   bus        : assoc_cache_if.slave (CPU request/ack and memory fill/write-through)
//   hitCount, missCount : saturating hit/miss counters, present only when CACHE_STATS_EN
//                         is defined
// Reads hit in one cycle, misses fill a whole block; every write goes through to memory and
// only updates the cache on a hit. Victim = lowest invalid way, else per-set round-robin.
module assoc_cache #(
  parameter int unsigned ADDR_W      = 15,
  parameter int unsigned BLOCK_WORDS = 4,
  parameter int unsigned SETS        = 256,
  parameter int unsigned WAYS        = 2
) (
  input  logic          clock,
  input  logic          rst,
  assoc_cache_if.slave  bus
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]   hitCount,
  output logic [31:0]   missCount
`endif
);
  localparam int unsigned OFF_W  = $clog2(BLOCK_WORDS);
  localparam int unsigned IDX_W  = $clog2(SETS);
  localparam int unsigned TAG_W  = ADDR_W - IDX_W - OFF_W;
  localparam int unsigned BLK_W  = 32 * BLOCK_WORDS;
  localparam int unsigned WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [1:0] {StIdle, StFill, StWrite} state_e;

  state_e stateQ, stateD;

  logic [WAYS-1:0]  validQ [SETS];
  logic [WAY_W-1:0] rrQ    [SETS];
  logic [TAG_W-1:0] tagQ   [SETS][WAYS];
  logic [BLK_W-1:0] dataQ  [SETS][WAYS];

  logic [ADDR_W-1:0] reqAddrQ, reqAddrD;
  logic [31:0]       outQ, outD;
  logic              ackQ, ackD, hitQ, hitD, missQ, missD;
  logic              memReadQ, memReadD, memWrQ, memWrD;
  logic [ADDR_W-1:0] memAddrQ, memAddrD, memWrAddrQ, memWrAddrD;
  logic [31:0]       memWrDataQ, memWrDataD;
  logic              fillEn, wordWrEn;

  // Lookup on the live bus address (accept cycle)
  logic [IDX_W-1:0] reqIdx;
  logic [TAG_W-1:0] reqTag;
  logic [OFF_W-1:0] reqOff;
  assign reqIdx = bus.cacheReadAddress[OFF_W +: IDX_W];
  assign reqTag = bus.cacheReadAddress[IDX_W+OFF_W +: TAG_W];
  assign reqOff = bus.cacheReadAddress[0 +: OFF_W];

  logic             lookupHit;
  logic [WAY_W-1:0] hitWay;
  logic [31:0]      hitWord;
  always_comb begin
    lookupHit = 1'b0;
    hitWay    = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (validQ[reqIdx][w] && tagQ[reqIdx][w] == reqTag) begin
        lookupHit = 1'b1;
        hitWay    = WAY_W'(w);
      end
    end
    hitWord = dataQ[reqIdx][hitWay][{reqOff, 5'd0} +: 32];
  end

  // Fill side works on the latched address
  logic [IDX_W-1:0] lIdx;
  logic [TAG_W-1:0] lTag;
  logic [OFF_W-1:0] lOff;
  assign lIdx = reqAddrQ[OFF_W +: IDX_W];
  assign lTag = reqAddrQ[IDX_W+OFF_W +: TAG_W];
  assign lOff = reqAddrQ[0 +: OFF_W];

  logic [WAY_W-1:0] victim;
  logic             foundInvalid;
  logic [WAY_W-1:0] rrNext;
  always_comb begin
    victim       = rrQ[lIdx];
    foundInvalid = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (!foundInvalid && !validQ[lIdx][w]) begin
        victim       = WAY_W'(w);
        foundInvalid = 1'b1;
      end
    end
    rrNext = (rrQ[lIdx] == WAY_W'(WAYS - 1)) ? '0 : rrQ[lIdx] + 1'b1;
  end

  always_comb begin
    stateD     = stateQ;
    reqAddrD   = reqAddrQ;
    outD       = outQ;
    ackD       = 1'b0;
    hitD       = 1'b0;
    missD      = 1'b0;
    memReadD   = memReadQ;
    memAddrD   = memAddrQ;
    memWrD     = memWrQ;
    memWrAddrD = memWrAddrQ;
    memWrDataD = memWrDataQ;
    fillEn     = 1'b0;
    wordWrEn   = 1'b0;
    unique case (stateQ)
      StIdle: begin
        if (bus.cpuReq) begin
          reqAddrD = bus.cacheReadAddress;
          hitD     = lookupHit;
          missD    = !lookupHit;
          if (bus.cpuWe) begin
            wordWrEn   = lookupHit;
            memWrD     = 1'b1;
            memWrAddrD = bus.cacheReadAddress;
            memWrDataD = bus.cpuWriteData;
            stateD     = StWrite;
          end else if (lookupHit) begin
            outD = hitWord;
            ackD = 1'b1;
          end else begin
            memReadD = 1'b1;
            memAddrD = {bus.cacheReadAddress[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            stateD   = StFill;
          end
        end
      end
      StFill: begin
        if (bus.memReady) begin
          fillEn   = 1'b1;
          outD     = bus.dataIn[{lOff, 5'd0} +: 32];
          ackD     = 1'b1;
          memReadD = 1'b0;
          stateD   = StIdle;
        end
      end
      StWrite: begin
        if (bus.memReady) begin
          ackD   = 1'b1;
          memWrD = 1'b0;
          stateD = StIdle;
        end
      end
      default: stateD = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      stateQ     <= StIdle;
      reqAddrQ   <= '0;
      outQ       <= '0;
      ackQ       <= 1'b0;
      hitQ       <= 1'b0;
      missQ      <= 1'b0;
      memReadQ   <= 1'b0;
      memAddrQ   <= '0;
      memWrQ     <= 1'b0;
      memWrAddrQ <= '0;
      memWrDataQ <= '0;
      for (int s = 0; s < SETS; s++) begin
        validQ[s] <= '0;
        rrQ[s]    <= '0;
      end
    end else begin
      stateQ     <= stateD;
      reqAddrQ   <= reqAddrD;
      outQ       <= outD;
      ackQ       <= ackD;
      hitQ       <= hitD;
      missQ      <= missD;
      memReadQ   <= memReadD;
      memAddrQ   <= memAddrD;
      memWrQ     <= memWrD;
      memWrAddrQ <= memWrAddrD;
      memWrDataQ <= memWrDataD;
      if (fillEn) begin
        validQ[lIdx][victim] <= 1'b1;
        // Pointer only advances when it actually picked the victim
        if (!foundInvalid) rrQ[lIdx] <= rrNext;
      end
    end
  end

  // Tag/data storage has no reset; gating on rst keeps an aborted fill from landing
  always_ff @(posedge clock) begin
    if (!rst) begin
      if (fillEn) begin
        tagQ[lIdx][victim]  <= lTag;
        dataQ[lIdx][victim] <= bus.dataIn;
      end
      if (wordWrEn) dataQ[reqIdx][hitWay][{reqOff, 5'd0} +: 32] <= bus.cpuWriteData;
    end
  end

  assign bus.out                 = outQ;
  assign bus.cpuAck              = ackQ;
  assign bus.Hit                 = hitQ;
  assign bus.Miss                = missQ;
  assign bus.memRead             = memReadQ;
  assign bus.memAddress          = memAddrQ;
  assign bus.memWriteCacheOutput = memWrQ;
  assign bus.memWriteAddress     = memWrAddrQ;
  assign bus.memWriteData        = memWrDataQ;

`ifdef CACHE_STATS_EN
  always_ff @(posedge clock) begin
    if (rst) begin
      hitCount  <= '0;
      missCount <= '0;
    end else begin
      if (hitQ && hitCount != '1)   hitCount  <= hitCount + 1'b1;
      if (missQ && missCount != '1) missCount <= missCount + 1'b1;
    end
  end
`endif
endmodule
